param_queue: RTL

- Parametrised successor to the 8-bit Queue, with configurable data width and depth.
- Compile-time FIFO/LIFO mode.
- Adds simultaneous push+pop, synchronous flush, occupancy count, almost-full flag and one-cycle overflow/underflow error pulses.
- Drop-in buffering element for the contest designs: keeps the 2-bit operation encoding and the out/empty/full semantics of the original block.

---
 rtl/param_queue_if.sv | 32 +++
 rtl/param_queue.sv | 128 ++++++++++++
 2 files changed

// File: rtl/param_queue_if.sv
// Operation/data bundle for param_queue: the master drives commands and push data,
// the slave returns popped data, occupancy flags and error pulses.
interface param_queue_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    // Handshake: no valid/ready. A command on operation is sampled at every rising
    // edge; the slave reports acceptance/rejection through the error pulses on the
    // following cycle, so the master never stalls.
    logic [1:0]        operation;
    logic              flush;
    logic [DATA_W-1:0] in;
    logic [DATA_W-1:0] out;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              underflow;

    modport master (
        output operation, flush, in,
        input  out, empty, full, almost_full, count, overflow, underflow
    );

    modport slave (
        input  operation, flush, in,
        output out, empty, full, almost_full, count, overflow, underflow
    );
endinterface

// File: rtl/param_queue.sv
// Parametrised FIFO/LIFO buffer with simultaneous push+pop, synchronous flush,
// occupancy count, almost-full flag and one-cycle overflow/underflow pulses.
module param_queue #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int MODE     = 0,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input logic         clk,
    input logic         rst,
    param_queue_if.slave bus
);
    localparam int  CW   = $clog2(DEPTH + 1);
    localparam int  PW   = $clog2(DEPTH);
    localparam bit  LIFO = (MODE == 1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              af_q, af_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic              do_push, do_pop;
    logic              mem_we;
    logic [PW-1:0]     mem_waddr;
    logic [PW-1:0]     top_idx;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign top_idx = PW'(count_q - CW'(1));

    // Decide what actually happens this edge; push+pop on an empty queue degrades to push.
    always_comb begin
        do_push = 1'b0;
        do_pop  = 1'b0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (!bus.flush) begin
            case (bus.operation)
                2'b01: if (full_q) ovf_d = 1'b1; else do_push = 1'b1;
                2'b10: if (empty_q) unf_d = 1'b1; else do_pop = 1'b1;
                2'b11: begin
                    do_push = 1'b1;
                    if (empty_q) unf_d = 1'b1; else do_pop = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        out_d     = out_q;
        mem_we    = do_push;
        mem_waddr = wr_ptr_q;
        if (LIFO) begin
            // Push+pop on a stack replaces the top element in place.
            mem_waddr = (do_push && do_pop) ? top_idx : PW'(count_q);
            if (do_pop) out_d = mem_q[top_idx];
        end else begin
            if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
            if (do_pop) begin
                out_d    = mem_q[rd_ptr_q];
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
        end

        count_d = count_q;
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (do_pop && !do_push) count_d = count_q - CW'(1);

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(DEPTH));
        af_d    = (count_d >= CW'(AF_LEVEL));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            out_q    <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            out_q    <= out_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is not reset; its contents are only ever read behind a valid count.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= bus.in;
    end

    assign bus.out         = out_q;
    assign bus.empty       = empty_q;
    assign bus.full        = full_q;
    assign bus.almost_full = af_q;
    assign bus.count       = count_q;
    assign bus.overflow    = ovf_q;
    assign bus.underflow   = unf_q;
endmodule
